// File: rtl/avram_pkg.sv
// Shared definitions for the Avalon on-chip RAM: FSM states, default
// parameters and the per-byte parity helper.
package avram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } avram_state_e;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_ADDR_W         = 11;
    localparam int DEF_READ_LATENCY   = 2;
    localparam int DEF_CLEAR_ON_RESET = 1;

    // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/avram_bank.sv
// Storage array with a lane-enabled write port and a registered read port
// (one cycle from read enable to rdata). rdata holds between reads.
module avram_bank #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [LANES-1:0]          be,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [LANES*LANE_W-1:0]   wdata,
    input  logic                      re,
    input  logic [ADDR_W-1:0]         raddr,
    output logic [LANES*LANE_W-1:0]   rdata
);

    logic [LANES-1:0][LANE_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[waddr][i] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/avalon_onchip_ram.sv
// Avalon-MM on-chip RAM slave with optional post-reset zero fill and a 1- or
// 2-cycle read pipeline. Define AVRAM_PARITY_EN to store/check per-byte parity.
//
// Handshake: a request is taken on a rising edge when
// chipselect & (read | write) & ~waitrequest; read+write together is a write only.
// Every accepted read yields exactly one readdatavalid beat, in order.
module avalon_onchip_ram
    import avram_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int READ_LATENCY   = DEF_READ_LATENCY,
    parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    input  logic                parity_inject,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                parity_err
);

    localparam int LANES = DATA_W / 8;
`ifdef AVRAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    avram_state_e            state;
    logic [ADDR_W:0]         clr_cnt;
    logic                    clearing;
    logic                    accept, wr_acc, rd_acc;
    logic                    bank_we;
    logic [LANES-1:0]        bank_be;
    logic [ADDR_W-1:0]       bank_waddr;
    logic [LANES*LANE_W-1:0] bank_wdata, bank_rdata;
    logic [DATA_W-1:0]       rd_word;
    logic                    rd_perr;
    logic                    rd_v1;

    // The extra counter bit marks the exit cycle after the last address is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt[ADDR_W]) begin
                        state   <= READY;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    assign clearing    = (state == CLEAR) && !clr_cnt[ADDR_W];
    assign waitrequest = reset || (state != READY) || !clken;
    assign accept      = chipselect && (read || write) && !waitrequest;
    assign wr_acc      = accept && write;
    assign rd_acc      = accept && read && !write;

    assign bank_we    = clearing || wr_acc;
    assign bank_be    = clearing ? '1 : byteenable;
    assign bank_waddr = clearing ? clr_cnt[ADDR_W-1:0] : address;

    always_comb begin
        bank_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            bank_wdata[i*LANE_W +: 8] = clearing ? 8'h00 : writedata[i*8 +: 8];
`ifdef AVRAM_PARITY_EN
            bank_wdata[i*LANE_W + 8] = clearing ? 1'b0
                                     : (byte_parity(writedata[i*8 +: 8]) ^ parity_inject);
`endif
        end
    end

`ifndef AVRAM_PARITY_EN
    logic unused_parity_inject;
    assign unused_parity_inject = parity_inject;
`endif

    avram_bank #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst   (reset),
        .we    (bank_we),
        .be    (bank_be),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (rd_acc),
        .raddr (address),
        .rdata (bank_rdata)
    );

    always_comb begin
        rd_word = '0;
        rd_perr = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            rd_word[i*8 +: 8] = bank_rdata[i*LANE_W +: 8];
`ifdef AVRAM_PARITY_EN
            if (byte_parity(bank_rdata[i*LANE_W +: 8]) != bank_rdata[i*LANE_W + 8])
                rd_perr = 1'b1;
`endif
        end
    end

    // The read pipeline ignores clken so in-flight reads always complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_v1 <= 1'b0;
        else       rd_v1 <= rd_acc;
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign readdata      = rd_word;
            assign readdatavalid = rd_v1;
            assign parity_err    = rd_v1 && rd_perr;
        end else begin : g_lat2
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    readdata      <= '0;
                    readdatavalid <= 1'b0;
                    parity_err    <= 1'b0;
                end else begin
                    readdatavalid <= rd_v1;
                    parity_err    <= rd_v1 && rd_perr;
                    if (rd_v1) readdata <= rd_word;
                end
            end
        end
    endgenerate

endmodule
